// File: rtl/sal_ddr_pkg.sv
// Shared SAL DDR2 definitions: DFI command encodings, responder error codes
// and the command decode helper.
package sal_ddr_pkg;

  // Address bit that selects all-bank precharge on PRE.
  localparam int unsigned DdrAllBankBit = 10;

  typedef enum logic [2:0] {
    CmdMrs  = 3'b000,
    CmdRef  = 3'b001,
    CmdPre  = 3'b010,
    CmdAct  = 3'b011,
    CmdWr   = 3'b100,
    CmdRd   = 3'b101,
    CmdRsvd = 3'b110,
    CmdNop  = 3'b111
  } dfi_cmd_e;

  typedef enum logic [3:0] {
    ErrNone       = 4'd0,
    ErrActOpen    = 4'd1,
    ErrClosedBank = 4'd2,
    ErrQueueOvf   = 4'd3,
    ErrRdEmpty    = 4'd4,
    ErrWrEmpty    = 4'd5,
    ErrRefOpen    = 4'd6
  } rsp_err_e;

  typedef struct packed {
    logic     valid;
    dfi_cmd_e cmd;
  } dfi_cmd_t;

  function automatic dfi_cmd_t decode_cmd(input logic cke, input logic cs_n,
                                          input logic [2:0] ras_cas_we);
    dfi_cmd_t c;
    c.valid = cke & ~cs_n;
    c.cmd   = dfi_cmd_e'(ras_cas_we);
    return c;
  endfunction

endpackage

// File: rtl/sal_dfi_rsp_addr_q.sv
// Small address FIFO for the DFI responder. A push to a full queue is only
// accepted when a pop happens in the same cycle; a pop on empty is ignored.
module sal_dfi_rsp_addr_q #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_q <= count_q + (PtrW + 1)'(1);
      if (do_pop && !do_push) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sal_dfi_responder.sv
// DFI-side PHY+DRAM stand-in: bank tracking, burst storage, fixed-latency reads.
// Define SAL_DFI_RSP_CHECK_EN to build in the sticky protocol checker.
module sal_dfi_responder
  import sal_ddr_pkg::*;
#(
  parameter int unsigned BA_W        = 3,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned COL_IDX_W   = 5,
  parameter int unsigned BURST_BEATS = 2,
  parameter int unsigned RD_LAT      = 3,
  parameter int unsigned Q_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dfi_cke,
  input  logic                  dfi_cs_n,
  input  logic                  dfi_ras_n,
  input  logic                  dfi_cas_n,
  input  logic                  dfi_we_n,
  input  logic [BA_W-1:0]       dfi_ba,
  input  logic [ADDR_W-1:0]     dfi_addr,
  input  logic                  dfi_wrdata_en,
  input  logic [DATA_W-1:0]     dfi_wrdata,
  input  logic [DATA_W/8-1:0]   dfi_wrdata_mask,
  input  logic                  dfi_rddata_en,
  output logic                  dfi_rddata_valid,
  output logic [DATA_W-1:0]     dfi_rddata,
  output logic                  err_o,
  output logic [3:0]            err_code_o
);

  localparam int unsigned IdxW     = BA_W + COL_IDX_W;
  localparam int unsigned BeatW    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int unsigned NumBanks = 1 << BA_W;
  localparam int unsigned NumWords = 1 << IdxW;
  localparam int unsigned StrbW    = DATA_W / 8;
  localparam logic [IdxW-1:0]  BaseMask = ~IdxW'(BURST_BEATS - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);

  typedef struct packed {
    logic            valid;
    logic            hit;
    logic [IdxW-1:0] idx;
  } rd_slot_t;

  dfi_cmd_t cmd;
  logic     is_act, is_pre, is_rd, is_wr, is_ref;

  assign cmd    = decode_cmd(dfi_cke, dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n});
  assign is_act = cmd.valid && (cmd.cmd == CmdAct);
  assign is_pre = cmd.valid && (cmd.cmd == CmdPre);
  assign is_rd  = cmd.valid && (cmd.cmd == CmdRd);
  assign is_wr  = cmd.valid && (cmd.cmd == CmdWr);
  assign is_ref = cmd.valid && (cmd.cmd == CmdRef);

  // Bank state
  logic [NumBanks-1:0]             bank_open_q;
  logic [NumBanks-1:0][ADDR_W-1:0] row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_q <= '0;
      row_q       <= '0;
    end else if (is_act) begin
      bank_open_q[dfi_ba] <= 1'b1;
      row_q[dfi_ba]       <= dfi_addr;
    end else if (is_pre) begin
      if (dfi_addr[DdrAllBankBit]) bank_open_q <= '0;
      else                         bank_open_q[dfi_ba] <= 1'b0;
    end
  end

  // Address queues
  logic [IdxW-1:0] cmd_base, rq_head, wq_head, rd_idx, wr_idx;
  logic            rq_full, rq_empty, rq_pop, wq_full, wq_empty, wq_pop;
  logic            rd_hit, wr_hit;
  logic [BeatW-1:0] rd_beat_q, wr_beat_q;

  assign cmd_base = {dfi_ba, dfi_addr[COL_IDX_W-1:0]} & BaseMask;

  sal_dfi_rsp_addr_q #(.Width(IdxW), .Depth(Q_DEPTH)) u_rd_q (
    .clk       (clk),
    .rst       (rst),
    .push      (is_rd),
    .push_data (cmd_base),
    .pop       (rq_pop),
    .head      (rq_head),
    .full      (rq_full),
    .empty     (rq_empty)
  );

  sal_dfi_rsp_addr_q #(.Width(IdxW), .Depth(Q_DEPTH)) u_wr_q (
    .clk       (clk),
    .rst       (rst),
    .push      (is_wr),
    .push_data (cmd_base),
    .pop       (wq_pop),
    .head      (wq_head),
    .full      (wq_full),
    .empty     (wq_empty)
  );

  assign rd_hit = dfi_rddata_en & ~rq_empty;
  assign wr_hit = dfi_wrdata_en & ~wq_empty;
  assign rq_pop = rd_hit & (rd_beat_q == LastBeat);
  assign wq_pop = wr_hit & (wr_beat_q == LastBeat);
  assign rd_idx = rq_head + IdxW'(rd_beat_q);
  assign wr_idx = wq_head + IdxW'(wr_beat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_beat_q <= '0;
      wr_beat_q <= '0;
    end else begin
      if (rd_hit) rd_beat_q <= rq_pop ? '0 : rd_beat_q + BeatW'(1);
      if (wr_hit) wr_beat_q <= wq_pop ? '0 : wr_beat_q + BeatW'(1);
    end
  end

  // Storage array, intentionally left unreset
  logic [DATA_W-1:0] mem_q [NumWords];

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      for (int unsigned i = 0; i < StrbW; i++) begin
        if (!dfi_wrdata_mask[i]) mem_q[wr_idx][i*8 +: 8] <= dfi_wrdata[i*8 +: 8];
      end
    end
  end

  // Read latency pipeline; the output register is the final stage.
  rd_slot_t rd_new, rd_tail;

  assign rd_new = '{valid: dfi_rddata_en, hit: rd_hit, idx: rd_idx};

  if (RD_LAT > 1) begin : g_pipe
    rd_slot_t pipe_q [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LAT - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= rd_new;
        for (int unsigned i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign rd_tail = pipe_q[RD_LAT-2];
  end else begin : g_no_pipe
    assign rd_tail = rd_new;
  end

  // Array read happens at the same edge as any write commit, so it sees old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      dfi_rddata_valid <= 1'b0;
      dfi_rddata       <= '0;
    end else begin
      dfi_rddata_valid <= rd_tail.valid;
      dfi_rddata       <= rd_tail.hit ? mem_q[rd_tail.idx] : '0;
    end
  end

`ifdef SAL_DFI_RSP_CHECK_EN
  rsp_err_e err_code_q, err_now;
  logic     err_q;
  logic     unused_state;

  always_comb begin
    err_now = ErrNone;
    if (is_act && bank_open_q[dfi_ba]) begin
      err_now = ErrActOpen;
    end else if ((is_rd || is_wr) && !bank_open_q[dfi_ba]) begin
      err_now = ErrClosedBank;
    end else if ((is_rd && rq_full && !rq_pop) || (is_wr && wq_full && !wq_pop)) begin
      err_now = ErrQueueOvf;
    end else if (is_ref && (|bank_open_q)) begin
      err_now = ErrRefOpen;
    end else if (dfi_rddata_en && rq_empty) begin
      err_now = ErrRdEmpty;
    end else if (dfi_wrdata_en && wq_empty) begin
      err_now = ErrWrEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else if (!err_q && (err_now != ErrNone)) begin
      err_q      <= 1'b1;
      err_code_q <= err_now;
    end
  end

  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign unused_state = ^row_q;
`else
  logic unused_state;

  assign err_o        = 1'b0;
  assign err_code_o   = 4'd0;
  assign unused_state = ^{row_q, bank_open_q, rq_full, wq_full};
`endif

endmodule

// File: tb/tb_sal_dfi_responder.sv
// Directed self-checking bench for sal_dfi_responder (default parameters).
module tb_sal_dfi_responder;

`ifdef SAL_DFI_RSP_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  localparam logic [2:0] CmdAct = 3'b011;
  localparam logic [2:0] CmdRd  = 3'b101;
  localparam logic [2:0] CmdWr  = 3'b100;
  localparam logic [2:0] CmdPre = 3'b010;
  localparam logic [2:0] CmdRef = 3'b001;

  localparam logic [63:0] DA  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] DB  = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] D1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3  = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4  = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D5  = 64'h5555_5555_5555_5555;
  localparam logic [63:0] D6  = 64'h6666_6666_6666_6666;
  localparam logic [63:0] DFF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DHI = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] DLO = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [2:0]  dfi_ba;
  logic [13:0] dfi_addr;
  logic        dfi_wrdata_en;
  logic [63:0] dfi_wrdata;
  logic [7:0]  dfi_wrdata_mask;
  logic        dfi_rddata_en;
  logic        dfi_rddata_valid;
  logic [63:0] dfi_rddata;
  logic        err_o;
  logic [3:0]  err_code_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sal_dfi_responder dut (
    .clk              (clk),
    .rst              (rst),
    .dfi_cke          (dfi_cke),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_ba           (dfi_ba),
    .dfi_addr         (dfi_addr),
    .dfi_wrdata_en    (dfi_wrdata_en),
    .dfi_wrdata       (dfi_wrdata),
    .dfi_wrdata_mask  (dfi_wrdata_mask),
    .dfi_rddata_en    (dfi_rddata_en),
    .dfi_rddata_valid (dfi_rddata_valid),
    .dfi_rddata       (dfi_rddata),
    .err_o            (err_o),
    .err_code_o       (err_code_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [13:0] addr);
    dfi_cs_n = 1'b0;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = c;
    dfi_ba = ba;
    dfi_addr = addr;
    tick();
    dfi_cs_n = 1'b1;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
  endtask

  task automatic wr_beats(input logic [63:0] d0, input logic [7:0] m0,
                          input logic [63:0] d1, input logic [7:0] m1);
    dfi_wrdata_en = 1'b1;
    dfi_wrdata = d0;
    dfi_wrdata_mask = m0;
    tick();
    dfi_wrdata = d1;
    dfi_wrdata_mask = m1;
    tick();
    dfi_wrdata_en = 1'b0;
  endtask

  // Two-beat read; valid must appear exactly three cycles after each enable cycle.
  task automatic rd_burst(input string tag, input logic [63:0] e0, input logic [63:0] e1);
    dfi_rddata_en = 1'b1;
    tick();
    tick();
    dfi_rddata_en = 1'b0;
    check_eq({tag, ".v_early"}, dfi_rddata_valid, 1'b0);
    tick();
    check_eq({tag, ".v0"}, dfi_rddata_valid, 1'b1);
    check_eq({tag, ".d0"}, dfi_rddata, e0);
    tick();
    check_eq({tag, ".v1"}, dfi_rddata_valid, 1'b1);
    check_eq({tag, ".d1"}, dfi_rddata, e1);
    tick();
    check_eq({tag, ".v_end"}, dfi_rddata_valid, 1'b0);
  endtask

  // Single enable beat with nothing queued: zero data, valid still returned.
  task automatic rd_empty_beat(input string tag);
    dfi_rddata_en = 1'b1;
    tick();
    dfi_rddata_en = 1'b0;
    tick();
    tick();
    check_eq({tag, ".v"}, dfi_rddata_valid, 1'b1);
    check_eq({tag, ".d"}, dfi_rddata, 64'd0);
  endtask

  task automatic check_err(input string tag, input logic [3:0] code);
    check_eq({tag, ".err"}, err_o, ChkEn ? (code != 4'd0) : 1'b0);
    check_eq({tag, ".code"}, err_code_o, ChkEn ? code : 4'd0);
  endtask

  initial begin
    rst = 1'b1;
    dfi_cke = 1'b1;
    dfi_cs_n = 1'b1;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
    dfi_ba = '0;
    dfi_addr = '0;
    dfi_wrdata_en = 1'b0;
    dfi_wrdata = '0;
    dfi_wrdata_mask = '0;
    dfi_rddata_en = 1'b0;
    do_reset();

    check_eq("rst.valid", dfi_rddata_valid, 1'b0);
    check_eq("rst.data", dfi_rddata, 64'd0);
    check_err("rst", 4'd0);

    // Basic write then read on bank 0, col 8
    cmd(CmdAct, 3'd0, 14'd5);
    cmd(CmdWr, 3'd0, 14'd8);
    wr_beats(DA, 8'h00, DB, 8'h00);
    cmd(CmdRd, 3'd0, 14'd8);
    rd_burst("basic", DA, DB);
    check_err("basic", 4'd0);

    // Byte masking over an all-ones word
    cmd(CmdWr, 3'd0, 14'd16);
    wr_beats(DFF, 8'h00, DFF, 8'h00);
    cmd(CmdWr, 3'd0, 14'd16);
    wr_beats(64'd0, 8'hF0, 64'd0, 8'h0F);
    cmd(CmdRd, 3'd0, 14'd16);
    rd_burst("mask", DHI, DLO);

    // Column 0, with an odd column address to exercise base alignment
    cmd(CmdWr, 3'd0, 14'd1);
    wr_beats(D5, 8'h00, D6, 8'h00);
    cmd(CmdRd, 3'd0, 14'd0);
    rd_burst("align", D5, D6);

    // Write beat commits on the same edge the read tail samples: old data wins
    cmd(CmdWr, 3'd0, 14'd24);
    wr_beats(D1, 8'h00, D2, 8'h00);
    cmd(CmdWr, 3'd0, 14'd24);
    cmd(CmdRd, 3'd0, 14'd24);
    dfi_rddata_en = 1'b1;
    tick();
    tick();
    dfi_rddata_en = 1'b0;
    dfi_wrdata_en = 1'b1;
    dfi_wrdata = D3;
    dfi_wrdata_mask = 8'h00;
    tick();
    dfi_wrdata = D4;
    check_eq("hz.v0", dfi_rddata_valid, 1'b1);
    check_eq("hz.d0", dfi_rddata, D1);
    tick();
    dfi_wrdata_en = 1'b0;
    check_eq("hz.d1", dfi_rddata, D2);
    tick();
    cmd(CmdRd, 3'd0, 14'd24);
    rd_burst("hz_new", D3, D4);
    check_err("hz", 4'd0);

    // Overflow: fifth RD dropped, four bursts intact, then queue empty
    do_reset();
    cmd(CmdAct, 3'd0, 14'd5);
    cmd(CmdRd, 3'd0, 14'd0);
    cmd(CmdRd, 3'd0, 14'd8);
    cmd(CmdRd, 3'd0, 14'd16);
    cmd(CmdRd, 3'd0, 14'd24);
    cmd(CmdRd, 3'd0, 14'd8);
    check_err("ovf", 4'd3);
    rd_burst("ovf0", D5, D6);
    rd_burst("ovf1", DA, DB);
    rd_burst("ovf2", DHI, DLO);
    rd_burst("ovf3", D3, D4);
    rd_empty_beat("ovf_drop");
    check_err("ovf_sticky", 4'd3);

    // Closed-bank read, later errors do not overwrite the code
    do_reset();
    cmd(CmdRd, 3'd2, 14'd0);
    check_err("closed", 4'd2);
    cmd(CmdAct, 3'd0, 14'd1);
    cmd(CmdAct, 3'd0, 14'd1);
    check_err("closed_sticky", 4'd2);

    do_reset();
    cmd(CmdAct, 3'd1, 14'd7);
    cmd(CmdAct, 3'd1, 14'd7);
    check_err("act_open", 4'd1);

    do_reset();
    cmd(CmdAct, 3'd1, 14'd7);
    cmd(CmdRef, 3'd0, 14'd0);
    check_err("ref_open", 4'd6);

    do_reset();
    wr_beats(DA, 8'h00, DA, 8'h00);
    check_err("wr_empty", 4'd5);

    do_reset();
    cmd(CmdAct, 3'd1, 14'd7);
    cmd(CmdPre, 3'd1, 14'd0);
    cmd(CmdAct, 3'd1, 14'd7);
    check_err("pre_one", 4'd0);
    cmd(CmdAct, 3'd2, 14'd7);
    cmd(CmdPre, 3'd0, 14'h0400);
    cmd(CmdRd, 3'd2, 14'd0);
    check_err("pre_all", 4'd2);

    // Reset while read data is streaming
    do_reset();
    cmd(CmdAct, 3'd0, 14'd5);
    cmd(CmdRd, 3'd0, 14'd8);
    cmd(CmdRd, 3'd0, 14'd16);
    dfi_rddata_en = 1'b1;
    tick();
    tick();
    tick();
    check_eq("mid.v", dfi_rddata_valid, 1'b1);
    check_eq("mid.d", dfi_rddata, DA);
    rst = 1'b1;
    dfi_rddata_en = 1'b0;
    tick();
    check_eq("mid_rst.v", dfi_rddata_valid, 1'b0);
    check_eq("mid_rst.d", dfi_rddata, 64'd0);
    check_err("mid_rst", 4'd0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("mid_flush.v", dfi_rddata_valid, 1'b0);
    rd_empty_beat("mid_q_empty");
    check_err("mid_q_empty", 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
